// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch and data access.
// dmem normally wins; a fairness counter forces an imem grant after FAIR_LIMIT dmem grants in a row.
module mem_arbiter #(
  parameter int FAIR_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rstn,

  input  logic        imem_valid,
  input  logic [63:0] imem_addr,

  input  logic        dmem_valid,
  input  logic [63:0] dmem_addr,
  input  logic        dmem_wen,
  input  logic [63:0] dmem_wdata,
  input  logic [7:0]  dmem_wmask,

  output logic        imem_done,
  output logic        dmem_done,
  output logic [63:0] rsp_rdata,
  output logic        busy,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  output logic        mem_wen,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,

  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rdata
);

  localparam int CW = $clog2(FAIR_LIMIT + 1);
  localparam logic [CW-1:0] FAIR_MAX = CW'(FAIR_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_e;

  state_e        state_q;
  logic          owner_dmem_q;
  logic [CW-1:0] fair_cnt_q;
  logic          imem_done_q;
  logic          dmem_done_q;
  logic [63:0]   rsp_rdata_q;
  logic          busy_q;
  logic          mem_req_valid_q;
  logic [63:0]   mem_addr_q;
  logic          mem_wen_q;
  logic [63:0]   mem_wdata_q;
  logic [7:0]    mem_wmask_q;

  logic          grant_dmem_d;
  logic [CW-1:0] fair_cnt_d;

  // Arbitration decision and fairness update, consumed only while IDLE.
  always_comb begin
    grant_dmem_d = dmem_valid && !(imem_valid && (fair_cnt_q == FAIR_MAX));
    fair_cnt_d   = fair_cnt_q;
    if (!imem_valid) begin
      fair_cnt_d = '0;
    end else if (grant_dmem_d) begin
      if (fair_cnt_q != FAIR_MAX) begin
        fair_cnt_d = fair_cnt_q + 1'b1;
      end
    end else begin
      fair_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= IDLE;
      owner_dmem_q    <= 1'b0;
      fair_cnt_q      <= '0;
      imem_done_q     <= 1'b0;
      dmem_done_q     <= 1'b0;
      rsp_rdata_q     <= '0;
      busy_q          <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_wen_q       <= 1'b0;
      mem_wdata_q     <= '0;
      mem_wmask_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          fair_cnt_q <= fair_cnt_d;
          if (imem_valid || dmem_valid) begin
            owner_dmem_q    <= grant_dmem_d;
            mem_req_valid_q <= 1'b1;
            busy_q          <= 1'b1;
            state_q         <= REQ;
            if (grant_dmem_d) begin
              mem_addr_q  <= dmem_addr;
              mem_wen_q   <= dmem_wen;
              mem_wdata_q <= dmem_wdata;
              mem_wmask_q <= dmem_wmask;
            end else begin
              mem_addr_q  <= imem_addr;
              mem_wen_q   <= 1'b0;
              mem_wdata_q <= '0;
              mem_wmask_q <= '0;
            end
          end
        end

        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= WAIT;
          end
        end

        // Done flags are raised on entry to DONE so they are high for that cycle only.
        WAIT: begin
          if (mem_rsp_valid) begin
            rsp_rdata_q <= mem_rdata;
            imem_done_q <= !owner_dmem_q;
            dmem_done_q <= owner_dmem_q;
            state_q     <= DONE;
          end
        end

        DONE: begin
          imem_done_q <= 1'b0;
          dmem_done_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign imem_done     = imem_done_q;
  assign dmem_done     = dmem_done_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign busy          = busy_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wen       = mem_wen_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wmask     = mem_wmask_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter FAIR_LIMIT, default 4, meaning: maximum consecutive dmem grants while imem waits; legal range 1..7.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 imem_valid  in  1  instruction-fetch request; held high until imem_done.
REQ-005 imem_addr  in  64  fetch address; stable while imem_valid is high.
REQ-006 dmem_valid  in  1  data request; held high until dmem_done.
REQ-007 dmem_addr / dmem_wen / dmem_wdata / dmem_wmask  in  64/1/64/8  data address, write enable, write data, byte mask; stable while dmem_valid is high.
REQ-008 imem_done / dmem_done  out  1/1  one-cycle completion pulse to the owning requester.
REQ-009 rsp_rdata  out  64  registered read data; meaningful only while imem_done or dmem_done is high.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 mem_req_valid  out  1  request to the shared memory port.
REQ-012 mem_req_ready  in  1  memory accepts the request when high together with mem_req_valid.
REQ-013 mem_addr / mem_wen / mem_wdata / mem_wmask  out  64/1/64/8  registered request fields.
REQ-014 mem_rsp_valid / mem_rdata  in  1/64  memory response, for reads and for writes.

Function
REQ-015 FSM states: IDLE, REQ, WAIT, DONE; one transaction in flight at most.
REQ-016 IDLE, no valid: remain in IDLE; no register changes except the fairness counter clear (REQ-022).
REQ-017 IDLE, any valid: choose owner per REQ-021, latch owner address/wen/wdata/wmask into mem_* registers (imem: wen=0, wdata=0, wmask=0), go to REQ.
REQ-018 REQ: mem_req_valid=1 with latched fields; on mem_req_ready=1 go to WAIT; otherwise stay, fields unchanged.
REQ-019 WAIT: mem_req_valid=0; on mem_rsp_valid=1 capture mem_rdata into rsp_rdata, go to DONE; mem_rsp_valid in any other state is ignored.
REQ-020 DONE: assert owner's done for exactly this cycle; go to IDLE; a new request may be sampled in the following IDLE cycle.
REQ-021 Arbitration: dmem wins when both valid, unless fairness count equals FAIR_LIMIT, in which case imem wins; a single valid requester always wins.
REQ-022 Fairness counter ($clog2(FAIR_LIMIT+1) bits): +1 on a dmem grant while imem_valid=1; cleared on any imem grant and in any IDLE cycle with imem_valid=0; saturates at FAIR_LIMIT.
REQ-023 Minimum latency: sample in IDLE at cycle t, mem_req_valid at t+1, done pulse at t+3 when ready at t+1 and response at t+2.
REQ-024 Requester dropping valid mid-transaction does not abort; transaction completes and done still pulses.
REQ-025 Addresses and masks pass through unchecked; no alignment handling.

Reset
REQ-026 rstn=0 forces IDLE immediately, including mid-transaction; the aborted transaction produces no done pulse.
REQ-027 Reset values: all outputs 0, rsp_rdata 0, mem_* registers 0, fairness counter 0.
REQ-028 First request is sampled in the first IDLE cycle after rstn rises.

Verification
REQ-029 imem_valid only, addr 0x1000, mem_req_ready=1 at t+1, mem_rsp_valid=1 with rdata 0x00000013 at t+2 -> mem_addr=0x1000 and mem_wen=0 at t+1, imem_done=1 and rsp_rdata=0x00000013 at t+3.
REQ-030 Both valid at t -> dmem served first; imem granted in the IDLE cycle after dmem_done.
REQ-031 FAIR_LIMIT=4, dmem_valid and imem_valid held high continuously -> grant order dmem x4, imem, dmem x4, imem.
REQ-032 dmem write, addr 0x2008, wdata 0xDEADBEEF, wmask 0x0F, mem_req_ready low for 3 cycles -> fields stable with mem_req_valid=1 for all 4 REQ cycles; dmem_done pulses once after the response.
REQ-033 rstn=0 during WAIT -> busy=0 and mem_req_valid=0 immediately; a later mem_rsp_valid=1 produces no done; the next request completes normally.
